// File: rtl/mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// mem_responder_pkg
//   Definitions shared by the processor and its memory responder: word and
//   address widths, the responder state encoding, and a helper that sizes
//   the storage index for a given word count.
// ---------------------------------------------------------------------------
package mem_responder_pkg;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 16;

  // ST_IDLE is all-zero so the reset value is IDLE; 2'b11 is illegal and is
  // steered back to IDLE by the FSM default branch.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Index width needed to address 'depth' words (never less than one bit).
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_array.sv
// ---------------------------------------------------------------------------
// mem_array
//   Single-port word storage: synchronous write, registered read.
//   Contents are never cleared by reset; only the read register is.
// Ports:
//   clk    in   clock
//   reset  in   async active-high reset (read register only)
//   en     in   perform an access this edge
//   we     in   1 = write wdata to addr, 0 = load mem[addr] into rdata
//   addr   in   word index (caller guarantees addr < DEPTH)
//   wdata  in   write data
//   rdata  out  registered read data
// ---------------------------------------------------------------------------
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int DEPTH = 65536,
  parameter int IDX_W = idx_width(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  // Storage write port; deliberately not reset so contents survive reset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem_q[addr] <= wdata;
    end
  end

  // Registered read port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= {WORD_W{1'b0}};
    end else if (en && !we) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//   Valid/ready memory slave for the processor. A request is accepted in
//   IDLE, waits WAIT_STATES extra edges, performs a single access on the
//   WAIT->RESP edge and holds the response until the processor takes it.
// Ports:
//   clk        in   clock
//   reset      in   async active-high reset (memory contents preserved)
//   req_valid  in   request present
//   req_ready  out  high only in IDLE
//   req_we     in   1 = write, 0 = read
//   req_addr   in   word address
//   req_wdata  in   write data
//   rsp_valid  out  high only in RESP
//   rsp_ready  in   response consumed on an edge where high
//   rsp_rdata  out  read data (0 for writes and errors)
//   rsp_err    out  address was >= DEPTH
// ---------------------------------------------------------------------------
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int WAIT_STATES = 2,
  parameter int DEPTH       = 65536
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int                IDX_W   = idx_width(DEPTH);
  localparam logic [3:0]        WS_L    = 4'(WAIT_STATES);
  // One extra bit so DEPTH = 65536 is representable in the range compare.
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);

  state_e            state_q,     state_d;
  logic [3:0]        cnt_q,       cnt_d;
  logic              we_q,        we_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [WORD_W-1:0] wdata_q,     wdata_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q,   rsp_err_d;
  logic              rd_hit_q,    rd_hit_d;

  logic              in_range_s;
  logic              mem_en_s;
  logic [WORD_W-1:0] mem_rdata_s;

  assign in_range_s = ({1'b0, addr_q} < DEPTH_L);

  // Next-state and access-strobe logic for the IDLE/WAIT/RESP sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rd_hit_d    = rd_hit_q;
    mem_en_s    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          // Latch the whole request now; req_* are ignored until IDLE again.
          we_d        = req_we;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          cnt_d       = WS_L;
          req_ready_d = 1'b0;
          state_d     = ST_WAIT;
        end else begin
          req_ready_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // The only cycle that touches storage, so a write commits once.
          mem_en_s    = in_range_s;
          rsp_err_d   = !in_range_s;
          rd_hit_d    = in_range_s && !we_q;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          // Return to IDLE without accepting; acceptance needs a later edge.
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rd_hit_d    = 1'b0;
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
        // Illegal encoding: recover to a clean IDLE.
        cnt_d       = 4'd0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rd_hit_d    = 1'b0;
        req_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any in-flight transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= {ADDR_W{1'b0}};
      wdata_q     <= {WORD_W{1'b0}};
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rd_hit_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rd_hit_q    <= rd_hit_d;
    end
  end

  mem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_mem_array (
    .clk   (clk),
    .reset (reset),
    .en    (mem_en_s),
    .we    (we_q),
    .addr  (addr_q[IDX_W-1:0]),
    .wdata (wdata_q),
    .rdata (mem_rdata_s)
  );

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  // Read register is loaded on the WAIT->RESP edge together with rd_hit_q
  // and is not touched again until the next access, so this stays stable
  // throughout RESP and reads as zero for writes, errors and after reset.
  assign rsp_rdata = rd_hit_q ? mem_rdata_s : {WORD_W{1'b0}};

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter: WAIT_STATES, default 2, extra cycles between request acceptance and response (0..15).
REQ-002 SHALL have parameter: DEPTH, default 65536, number of 16-bit words implemented (1..65536).
REQ-003 SHALL have port: clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: req_valid  input  1  processor presents a request.
REQ-006 SHALL have port: req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port: req_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have port: req_addr  input  16  word address.
REQ-009 SHALL have port: req_wdata  input  16  write data.
REQ-010 SHALL have port: rsp_valid  output  1  response available.
REQ-011 SHALL have port: rsp_ready  input  1  processor consumes the response.
REQ-012 SHALL have port: rsp_rdata  output  16  read data; 0 for writes and errors.
REQ-013 SHALL have port: rsp_err  output  1  address >= DEPTH.

Function
REQ-014 SHALL implement states IDLE, WAIT, RESP; req_ready=1 only in IDLE; rsp_valid=1 only in RESP.
REQ-015 SHALL accept a request on an edge where state=IDLE and req_valid=1; latch req_we, req_addr, req_wdata; load wait counter with WAIT_STATES; go to WAIT.
REQ-016 SHALL, in WAIT, decrement the counter each edge while nonzero; on an edge with counter=0, perform the access and go to RESP.
REQ-017 SHALL yield latency: rsp_valid first high after the (WAIT_STATES+1)th edge following the accepting edge; WAIT_STATES=0 gives 1 edge.
REQ-018 SHALL, for an in-range read, register rsp_rdata = mem[addr] on the WAIT->RESP edge.
REQ-019 SHALL, for an in-range write, update mem[addr] on the WAIT->RESP edge, exactly once; rsp_rdata=0.
REQ-020 SHALL, for addr >= DEPTH, perform no write, set rsp_err=1, rsp_rdata=0; the response still completes normally.
REQ-021 SHALL hold rsp_valid, rsp_rdata, rsp_err stable in RESP until an edge with rsp_ready=1, then go to IDLE.
REQ-022 SHALL NOT accept a new request on the RESP->IDLE edge; back-to-back throughput is one request per WAIT_STATES+3 edges minimum.
REQ-023 SHALL ignore req_* inputs outside IDLE; changes to them after acceptance SHALL NOT affect the transaction.
REQ-024 SHALL give read-after-write to the same address the newly written value.
REQ-025 SHALL treat an illegal state encoding as IDLE on the next edge.

Reset
REQ-026 SHALL, on reset assertion (any state, asynchronously), force state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=1 after deassertion.
REQ-027 SHALL abort an in-flight transaction on reset; a write not yet committed SHALL NOT be performed.
REQ-028 SHALL NOT clear memory contents on reset; memory is initialised only by load at simulation start.

Structure
REQ-029 SHALL take WORD width (16), address width (16) and state encodings from the shared processor package, also used by processor.
REQ-030 SHALL place storage in one sub-module mem_array (synchronous write, registered read, one port) instantiated once.

Verification
REQ-031 SHALL test: WAIT_STATES=2, write addr 0x0010 data 0xBEEF, rsp_ready=1 -> rsp_valid after 3 edges, rsp_err=0, rsp_rdata=0; then read 0x0010 -> rsp_rdata=0xBEEF.
REQ-032 SHALL test: WAIT_STATES=0, read 0x0000 preloaded 0x1234 -> rsp_valid after 1 edge, rsp_rdata=0x1234.
REQ-033 SHALL test: rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_rdata stable, req_ready=0, new req_valid ignored.
REQ-034 SHALL test: DEPTH=256, write 0x0100 data 0xFFFF -> rsp_err=1, rsp_rdata=0, mem[0x00] unchanged.
REQ-035 SHALL test: reset pulse during WAIT of write 0x0020 data 0xAAAA -> rsp_valid=0, state IDLE, later read 0x0020 returns prior value.
